mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Round-robin arbiter and read sequencer that shares the single-port 0..7 x 0..7 times-table memory (64 x 6-bit, address = a*8+b) between two requesters.
- Accepts one operand pair per cycle, drives the memory enable/address, tracks in-flight reads through a latency-matched pipeline, and returns each product tagged with the originating requester.
- Sits between the client logic and the times-table memory instance.

Parameters:
- READ_LATENCY, 1, edges from the edge that samples mem_en/mem_addr to valid mem_dout; supported range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 request. Held with a0/b0 stable until gnt0.
- a0  in  3  requester 0 operand a (0..7).
- b0  in  3  requester 0 operand b (0..7).
- gnt0  out  1  combinational grant to requester 0. Operands are consumed at the edge where gnt0=1.
- req1, a1, b1, gnt1  (in 1, in 3, in 3, out 1)  same as requester 0.
- mem_en  out  1  memory read enable (registered).
- mem_addr  out  6  memory address {a,b} (registered).
- mem_dout  in  6  memory read data.
- result  out  6  product (registered).
- result_valid  out  1  one-cycle pulse per completed read.
- result_id  out  1  requester that issued the read.
- busy  out  1  high while any read is in flight (mem_en or pipeline stage valid).

Behaviour:
- Reset (sync, rst=1 at an edge):
  - mem_en=0, mem_addr=0, result=0, result_valid=0, result_id=0.
  - Pipeline valid bits cleared, priority pointer=0.
  - gnt0/gnt1 forced 0 while rst=1.
  - Reset mid-operation discards all in-flight reads; no result_valid for them afterwards.
- Arbitration (combinational, one grant max):
  - Only req0 high: gnt0=1. Only req1 high: gnt1=1.
  - Both high: grant goes to the requester selected by the priority pointer.
  - No req: no grant.
- Priority pointer:
  - On any edge with a grant, the pointer becomes the non-granted requester.
  - With no grant it holds.
  - Result: strict alternation under continuous contention; no starvation.
- Issue:
  - At an edge with a grant, register mem_en=1, mem_addr={aX,bX}, and the tag X into stage 0.
  - Edge with no grant: mem_en=0, mem_addr holds its last value.
  - One issue per cycle; fully pipelined, no stall.
- Return pipeline:
  - A shift register of READ_LATENCY+1 {valid,id} stages follows mem_en.
  - When the final stage is valid, result<=mem_dout, result_id<=tag, result_valid<=1. Otherwise result_valid<=0 and result/result_id hold.
  - Latency: result_valid is high in the cycle following edge G+READ_LATENCY+1, where G is the grant edge.
  - Results return in issue order.
- Widths: a*8+b fits 6 bits (max 63). Memory contents are 0..49, passed through unmodified.
- No backpressure on results: consumers must accept every result_valid pulse.
- req dropped without a grant: legal, no effect.
- Simultaneous rst and req: rst wins; no grant, pointer=0.

Decomposition:
- Shared package mult_pkg:
  - constants OP_W=3, ADDR_W=6, RES_W=6, N_REQ=2.
  - function/macro for the address {a,b}.
- Natural sub-module: rr_arb2 (two-input round-robin grant + pointer register), reusable elsewhere.
- Pipeline and issue registers stay in mult_arbiter.
- Bench instantiates the real times-table memory, or a behavioural 64x6 ROM with a READ_LATENCY-deep output delay.

Test Plan (READ_LATENCY=1 unless stated):
- Single request: req0=1, a0=3, b0=5 for one cycle.
  -> gnt0=1 that cycle; mem_en=1 with mem_addr=29 the next cycle; result=15, result_id=0, result_valid pulse 2 edges after grant; busy returns to 0 afterwards.
- Contention: req0 and req1 held for 4 cycles, operands (7,7) and (2,6).
  -> grants alternate 0,1,0,1; results 49,12,49,12 with ids 0,1,0,1, back-to-back one per cycle.
- Pointer hold: req1 alone granted, then idle 3 cycles, then both request.
  -> requester 0 granted first; then requester 1.
- Boundary operands: (0,0), (7,0), (0,7), (7,7).
  -> mem_addr 0, 56, 7, 63; results 0, 0, 0, 49.
- Reset mid-flight: issue 2 reads, assert rst at the edge after the second grant.
  -> no result_valid for either read; all outputs 0; next request after reset is served normally with correct latency.
- READ_LATENCY=3: single request (4,6).
  -> result=24, result_valid 4 edges after grant; continuous stream keeps order and 1/cycle throughput.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and helpers for the times-table arbiter slice.
// The times-table memory is 64 x 6-bit, addressed by {a, b}.
package mult_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned RES_W  = 6;
  localparam int unsigned N_REQ  = 2;

  // Which requester wins when both ask in the same cycle.
  typedef enum logic {
    PriReq0 = 1'b0,
    PriReq1 = 1'b1
  } pri_e;

  // Memory address for operand pair (a, b): a*8 + b.
  function automatic logic [ADDR_W-1:0] mk_addr(input logic [OP_W-1:0] a,
                                                input logic [OP_W-1:0] b);
    return {a, b};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered priority pointer.
// After any grant the pointer moves to the requester that was not granted.
module rr_arb2
  import mult_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  pri_e pri_q, pri_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    pri_d  = pri_q;

    // Reset suppresses grants so no operand is consumed on a reset edge.
    if (!rst_i) begin
      if (pri_q == PriReq0) begin
        gnt0_o = req0_i;
        gnt1_o = req1_i & ~req0_i;
      end else begin
        gnt1_o = req1_i;
        gnt0_o = req0_i & ~req1_i;
      end
    end

    if (gnt0_o) begin
      pri_d = PriReq1;
    end else if (gnt1_o) begin
      pri_d = PriReq0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pri_q <= PriReq0;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares the times-table memory between two requesters: round-robin grant, registered
// issue of mem_en/mem_addr, and a latency-matched tag pipeline returning tagged products.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [OP_W-1:0]   a0,
  input  logic [OP_W-1:0]   b0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [OP_W-1:0]   a1,
  input  logic [OP_W-1:0]   b1,
  output logic              gnt1,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [RES_W-1:0]  mem_dout,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  output logic              result_id,
  output logic              busy
);

  // Final tag stage lines up with the edge at which mem_dout holds the read data.
  localparam int unsigned Last = READ_LATENCY;

  logic [N_REQ-1:0]  gnt;
  logic              issue;

  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [Last:0]     vld_q, vld_d;
  logic [Last:0]     id_q, id_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              result_id_q, result_id_d;

  rr_arb2 u_arb (
    .clk_i  (clk),
    .rst_i  (rst),
    .req0_i (req0),
    .req1_i (req1),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign gnt   = {gnt1, gnt0};
  assign issue = |gnt;

  always_comb begin
    mem_en_d   = issue;
    mem_addr_d = mem_addr_q;
    if (gnt0) begin
      mem_addr_d = mk_addr(a0, b0);
    end else if (gnt1) begin
      mem_addr_d = mk_addr(a1, b1);
    end

    vld_d = {vld_q[Last-1:0], issue};
    id_d  = {id_q[Last-1:0], gnt1};

    result_valid_d = vld_q[Last];
    result_d       = result_q;
    result_id_d    = result_id_q;
    if (vld_q[Last]) begin
      result_d    = mem_dout;
      result_id_d = id_q[Last];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q       <= 1'b0;
      mem_addr_q     <= '0;
      vld_q          <= '0;
      id_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= 1'b0;
    end else begin
      mem_en_q       <= mem_en_d;
      mem_addr_q     <= mem_addr_d;
      vld_q          <= vld_d;
      id_q           <= id_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_addr     = mem_addr_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign result_id    = result_id_q;
  assign busy         = mem_en_q | (|vld_q);

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: READ_LATENCY=1 and READ_LATENCY=3 instances driven in lockstep,
// each with a behavioural times-table ROM; expected products go through per-instance queues.
module tb_mult_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic       gnt0_1, gnt1_1, mem_en_1, result_valid_1, result_id_1, busy_1;
  logic [5:0] mem_addr_1, mem_dout_1, result_1;
  logic       gnt0_3, gnt1_3, mem_en_3, result_valid_3, result_id_3, busy_3;
  logic [5:0] mem_addr_3, mem_dout_3, result_3;

  mult_arbiter #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0_1),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1_1),
    .mem_en(mem_en_1), .mem_addr(mem_addr_1), .mem_dout(mem_dout_1),
    .result(result_1), .result_valid(result_valid_1), .result_id(result_id_1),
    .busy(busy_1)
  );

  mult_arbiter #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0_3),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1_3),
    .mem_en(mem_en_3), .mem_addr(mem_addr_3), .mem_dout(mem_dout_3),
    .result(result_3), .result_valid(result_valid_3), .result_id(result_id_3),
    .busy(busy_3)
  );

  // Behavioural ROM: read sampled on the enable edge, data delayed by READ_LATENCY edges.
  function automatic logic [5:0] rom(input logic [5:0] addr);
    logic [5:0] x, y;
    x = {3'b000, addr[5:3]};
    y = {3'b000, addr[2:0]};
    return x * y;
  endfunction

  logic [5:0] md1 [1];
  logic [5:0] md3 [3];
  always @(posedge clk) begin
    if (mem_en_1) md1[0] <= rom(mem_addr_1);
  end
  always @(posedge clk) begin
    if (mem_en_3) md3[0] <= rom(mem_addr_3);
    md3[1] <= md3[0];
    md3[2] <= md3[1];
  end
  assign mem_dout_1 = md1[0];
  assign mem_dout_3 = md3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit         id;
    logic [5:0] res;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  // Result monitors: every result_valid must match the queue head at its expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (result_valid_1 === 1'b1) begin
      if (q1.size() == 0) begin
        check("L1 result_valid with nothing outstanding", result_valid_1, 0);
      end else begin
        e = q1.pop_front();
        check("L1 result", result_1, e.res);
        check("L1 result_id", result_id_1, e.id);
        check("L1 result cycle", cyc, e.cyc);
      end
    end else if (q1.size() > 0 && q1[0].cyc < cyc) begin
      check("L1 result_valid missing", result_valid_1, 1);
      q1.delete(0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (result_valid_3 === 1'b1) begin
      if (q3.size() == 0) begin
        check("L3 result_valid with nothing outstanding", result_valid_3, 0);
      end else begin
        e = q3.pop_front();
        check("L3 result", result_3, e.res);
        check("L3 result_id", result_id_3, e.id);
        check("L3 result cycle", cyc, e.cyc);
      end
    end else if (q3.size() > 0 && q3[0].cyc < cyc) begin
      check("L3 result_valid missing", result_valid_3, 1);
      q3.delete(0);
    end
  end

  // Memory-side checker: the expected mem_en/mem_addr for an edge is latched on that edge.
  logic       exp_en = 1'b0;
  logic [5:0] exp_addr = '0;
  bit         arm = 1'b0;
  logic       chk_en;
  logic [5:0] chk_addr;
  bit         chk_arm = 1'b0;

  always @(posedge clk) begin
    chk_en   <= exp_en;
    chk_addr <= exp_addr;
    chk_arm  <= arm;
  end

  always @(negedge clk) begin
    if (chk_arm) begin
      check("L1 mem_en", mem_en_1, chk_en);
      check("L1 mem_addr", mem_addr_1, chk_addr);
      check("L3 mem_en", mem_en_3, chk_en);
      check("L3 mem_addr", mem_addr_3, chk_addr);
    end
  end

  // One cycle of stimulus. eg: expected grant 0, 1, or 2 for none; ep: expected product.
  task automatic drive(input bit r0, input logic [2:0] xa0, input logic [2:0] xb0,
                       input bit r1, input logic [2:0] xa1, input logic [2:0] xb1,
                       input int eg, input logic [5:0] ep, input bit push);
    exp_t e;
    @(negedge clk);
    req0 = r0; a0 = xa0; b0 = xb0;
    req1 = r1; a1 = xa1; b1 = xb1;
    #1;
    check("L1 gnt0", gnt0_1, eg == 0);
    check("L1 gnt1", gnt1_1, eg == 1);
    check("L3 gnt0", gnt0_3, eg == 0);
    check("L3 gnt1", gnt1_3, eg == 1);
    exp_en = (eg != 2);
    if (eg == 0) exp_addr = {xa0, xb0};
    else if (eg == 1) exp_addr = {xa1, xb1};
    if (eg != 2 && push) begin
      e.id  = (eg == 1);
      e.res = ep;
      e.cyc = cyc + 3;  // grant edge cyc+1, result seen after edge +READ_LATENCY+1
      q1.push_back(e);
      e.cyc = cyc + 5;
      q3.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 2, 0, 0);
  endtask

  // Holds rst for one edge with the given requests asserted; reset must win.
  task automatic do_reset(input bit r);
    @(negedge clk);
    rst = 1'b1;
    req0 = r; a0 = 3'd1; b0 = 3'd1;
    req1 = r; a1 = 3'd2; b1 = 3'd2;
    exp_en = 1'b0;
    exp_addr = '0;
    #1;
    check("gnt0 during reset", gnt0_1, 0);
    check("gnt1 during reset", gnt1_1, 0);
    @(negedge clk);
    check("L1 mem_en after reset", mem_en_1, 0);
    check("L1 mem_addr after reset", mem_addr_1, 0);
    check("L1 result after reset", result_1, 0);
    check("L1 result_valid after reset", result_valid_1, 0);
    check("L1 result_id after reset", result_id_1, 0);
    check("L1 busy after reset", busy_1, 0);
    check("L3 result after reset", result_3, 0);
    check("L3 result_valid after reset", result_valid_3, 0);
    check("L3 busy after reset", busy_3, 0);
    rst = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    arm = 1'b1;
  endtask

  initial begin
    do_reset(0);

    // Single request (3,5): addr 29, product 15.
    drive(1, 3, 5, 0, 0, 0, 0, 15, 1);
    idle(1);
    check("L1 busy in flight", busy_1, 1);
    check("L3 busy in flight", busy_3, 1);
    idle(6);
    check("L1 busy drained", busy_1, 0);
    check("L3 busy drained", busy_3, 0);

    // Pointer was left at requester 1; reset must return it to requester 0.
    do_reset(0);

    // Contention: (7,7) vs (2,6) alternate 0,1,0,1.
    drive(1, 7, 7, 1, 2, 6, 0, 49, 1);
    drive(1, 7, 7, 1, 2, 6, 1, 12, 1);
    drive(1, 7, 7, 1, 2, 6, 0, 49, 1);
    drive(1, 7, 7, 1, 2, 6, 1, 12, 1);
    idle(6);

    // Pointer hold: req1 alone, idle, both -> 0 first then 1.
    drive(0, 0, 0, 1, 1, 4, 1, 4, 1);
    idle(3);
    drive(1, 5, 5, 1, 3, 2, 0, 25, 1);
    drive(0, 0, 0, 1, 3, 2, 1, 6, 1);
    // And the mirror case: req0 alone, idle, both -> 1 first then 0.
    drive(1, 2, 2, 0, 0, 0, 0, 4, 1);
    idle(3);
    drive(1, 1, 3, 1, 2, 5, 1, 10, 1);
    drive(1, 1, 3, 0, 0, 0, 0, 3, 1);
    idle(6);

    // Boundary operands: addresses 0, 56, 7, 63.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 7, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 7, 0, 0, 0, 0, 0, 1);
    drive(1, 7, 7, 0, 0, 0, 0, 49, 1);
    idle(6);

    // Reset mid-flight: both reads discarded, then service resumes with pointer at 0.
    drive(1, 2, 3, 0, 0, 0, 0, 6, 0);
    drive(0, 0, 0, 1, 4, 4, 1, 16, 0);
    do_reset(1);
    idle(6);
    drive(1, 6, 6, 1, 3, 3, 0, 36, 1);
    drive(0, 0, 0, 1, 3, 3, 1, 9, 1);
    idle(6);

    // (4,6) alone, then a back-to-back stream.
    drive(1, 4, 6, 0, 0, 0, 0, 24, 1);
    idle(6);
    drive(1, 4, 6, 0, 0, 0, 0, 24, 1);
    drive(1, 1, 1, 0, 0, 0, 0, 1, 1);
    drive(1, 2, 7, 0, 0, 0, 0, 14, 1);
    drive(1, 5, 3, 0, 0, 0, 0, 15, 1);
    idle(8);

    check("L1 outstanding results", q1.size(), 0);
    check("L3 outstanding results", q3.size(), 0);
    check("L1 busy at end", busy_1, 0);
    check("L3 busy at end", busy_3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
